// File: rtl/rstgen_pkg.sv
// Shared definitions for the reset generator.
// - state_t   : reset-sequencer FSM states.
// - cnt_width : width of a counter that must hold the largest of three
//               terminal values.
package rstgen_pkg;

    typedef enum logic [2:0] {
        RST,    // board reset asserted or synchroniser not yet released
        HOLD,   // all resets asserted, counting HOLD_CYCLES
        GAP1,   // async resets released, sync reset still asserted
        GAP2,   // all resets released, clock still disabled
        RUN     // steady state
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Release synchroniser for the board reset.
// Assertion is asynchronous (every stage clears at once); release shifts a
// 1 through STAGES flops, so the last stage rises on edge STAGES after
// i_reset_async_n goes high.
// Ports:
// - i_clock          free-running clock
// - i_reset_async_n  board reset, asynchronous, active-low
// - release_edge     high during the cycle whose closing edge makes the last
//                    stage rise, so a consumer registering on that edge
//                    moves in step with the synchroniser output
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset_async_n,
    output logic release_edge
);

    logic [STAGES-1:0] stages;

    // NOTE: non-blocking assignment, so each stage takes the value its
    // predecessor held before this edge; blocking would collapse the chain.
    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGES-2:0], 1'b1};
        end
    end

    assign release_edge = stages[STAGES-2] & ~stages[STAGES-1];

endmodule

// File: rtl/reset_gen_ctrl.sv
// Reset and clock-enable generator for the downstream register banks.
// Asserts all resets asynchronously on the board reset, then releases them
// in stages: async resets, then the sync reset, then the clock enable.
// Optional watchdog built only when the macro RSTGEN_WDT_EN is defined.
// Ports:
// - i_clock          free-running clock, rising edge
// - i_reset_async_n  board reset, asynchronous, active-low
// - i_sw_reset       synchronous software reset request (level)
// - i_wdt_kick       watchdog service pulse (ignored without RSTGEN_WDT_EN)
// - o_reset_sync     active-high reset for sync-reset flops
// - o_reset_async    active-high reset for async-reset flops
// - o_reset_async_n  active-low reset for async-reset flops
// - o_clock_enable   gated-clock enable
// - o_ready          high while in RUN
// - o_wdt_fired      sticky watchdog-caused-reset flag
module reset_gen_ctrl
    import rstgen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int RELEASE_GAP = 4,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic i_clock,
    input  logic i_reset_async_n,
    input  logic i_sw_reset,
    input  logic i_wdt_kick,
    output logic o_reset_sync,
    output logic o_reset_async,
    output logic o_reset_async_n,
    output logic o_clock_enable,
    output logic o_ready,
    output logic o_wdt_fired
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, RELEASE_GAP, WDT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             release_edge;
    logic             wdt_expire;
    logic             restart;

    reset_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clock         (i_clock),
        .i_reset_async_n (i_reset_async_n),
        .release_edge    (release_edge)
    );

`ifdef RSTGEN_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] wdt_count;
    logic             wdt_fired;

    // Expiry acts on the edge after the count reaches its terminal value.
    assign wdt_expire = (state == RUN) && (wdt_count == WDT_LAST);

    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            wdt_count <= '0;
            wdt_fired <= 1'b0;
        end else begin
            if (state != RUN || i_sw_reset || wdt_expire || i_wdt_kick) begin
                wdt_count <= '0;
            end else if (wdt_count != WDT_LAST) begin
                wdt_count <= wdt_count + 1'b1;
            end
            // A software reset in the same cycle takes the blame instead.
            if (wdt_expire && !i_sw_reset) begin
                wdt_fired <= 1'b1;
            end
        end
    end

    assign o_wdt_fired = wdt_fired;
`else
    logic unused_kick;
    assign unused_kick = i_wdt_kick;
    assign wdt_expire  = 1'b0;
    assign o_wdt_fired = 1'b0;
`endif

    // Software and watchdog restarts are ignored until the board release
    // has reached the sequencer.
    assign restart = (state != RST) && (i_sw_reset || wdt_expire);

    // NOTE: every output is a flop written alongside the state, so downstream
    // logic never sees a decode glitch from the state register.
    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            state           <= RST;
            count           <= '0;
            o_reset_sync    <= 1'b1;
            o_reset_async   <= 1'b1;
            o_reset_async_n <= 1'b0;
            o_clock_enable  <= 1'b0;
            o_ready         <= 1'b0;
        end else if (restart) begin
            state           <= HOLD;
            count           <= '0;
            o_reset_sync    <= 1'b1;
            o_reset_async   <= 1'b1;
            o_reset_async_n <= 1'b0;
            o_clock_enable  <= 1'b0;
            o_ready         <= 1'b0;
        end else begin
            case (state)
                RST: begin
                    if (release_edge) begin
                        state <= HOLD;
                        count <= '0;
                    end
                end
                HOLD: begin
                    if (count == HOLD_LAST) begin
                        state           <= GAP1;
                        count           <= '0;
                        o_reset_async   <= 1'b0;
                        o_reset_async_n <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                GAP1: begin
                    if (count == GAP_LAST) begin
                        state        <= GAP2;
                        count        <= '0;
                        o_reset_sync <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                GAP2: begin
                    if (count == GAP_LAST) begin
                        state          <= RUN;
                        count          <= '0;
                        o_clock_enable <= 1'b1;
                        o_ready        <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RUN: begin
                    count <= '0;
                end
                default: begin
                    state <= RST;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
